// File: rtl/arbitro_barramento.sv
// -----------------------------------------------------------------------------
// arbitro_barramento
//   Round-robin arbiter that shares one bus among 2**SEL_W (= 8) requesters.
//   A winner keeps the bus until it asserts done or drops its request.
//   Every hand-over is followed by one dead (turnaround) cycle.
//   The one-hot grant comes from a decodificador driven by the registered
//   owner index, so gnt can never be multi-hot.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, an owner is forcibly released after MAX_HOLD grant cycles.
//     A one-cycle pulse appears on the timeout port during the turnaround.
//     The MAX_HOLD/CNT_W parameters and the timeout port exist only in that build.
//
// Ports
//   clock      in   1  single clock, posedge
//   reset_n    in   1  asynchronous, active-low reset
//   req        in   8  request lines, bit i = requester i
//   done       in   1  owner releases the bus (only looked at while granted)
//   gnt        out  8  one-hot grant, zero outside GRANT
//   gnt_idx    out  3  registered owner index; holds its value while idle
//   gnt_valid  out  1  high while a grant is active
//   timeout    out  1  forced-release pulse (ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------

// 3->8 (generally SEL_W -> 2**SEL_W) one-hot decoder
module decodificador #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]      sel_i,
   output logic [(1<<SEL_W)-1:0] dec_o
);
   always_comb begin
      dec_o        = '0;
      dec_o[sel_i] = 1'b1;
   end
endmodule

module arbitro_barramento #(
   parameter int SEL_W    = 3
`ifdef ARB_TIMEOUT_EN
  ,parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5      // needs 2**CNT_W > MAX_HOLD
`endif
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [(1<<SEL_W)-1:0]  req,
   input  logic                   done,
   output logic [(1<<SEL_W)-1:0]  gnt,
   output logic [SEL_W-1:0]       gnt_idx,
   output logic                   gnt_valid
`ifdef ARB_TIMEOUT_EN
  ,output logic                   timeout
`endif
);
   localparam int NREQ = 1 << SEL_W;

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr_q,   ptr_d;     // highest-priority requester for next pick
   logic [SEL_W-1:0] idx_q,   idx_d;     // current / last owner
   logic [SEL_W-1:0] sel;
   logic [SEL_W-1:0] cand;
   logic             any_req;
   logic             rel;
   logic [NREQ-1:0]  dec;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
   logic             forced;
`endif

   // Round-robin pick: first requester at or after ptr_q, wrapping.
   // Scanning offsets from high to low lets the smallest offset win.
   always_comb begin
      any_req = |req;
      sel     = ptr_q;
      cand    = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         cand = ptr_q + SEL_W'(i);
         if (req[cand]) sel = cand;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      rel     = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      forced  = 1'b0;
`endif
      case (state_q)
         S_IDLE, S_RELEASE: begin
            // RELEASE and IDLE pick the same way; RELEASE just never stays put
            if (any_req) begin
               state_d = S_GRANT;
               idx_d   = sel;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            // Other requests never preempt; only the owner can give up the bus.
            rel = done | ~req[idx_q];
`ifdef ARB_TIMEOUT_EN
            forced = ~rel & (cnt_q == CNT_W'(MAX_HOLD-1));
            tmo_d  = forced;
            if (rel | forced) begin
`else
            if (rel) begin
`endif
               state_d = S_RELEASE;
               ptr_d   = idx_q + SEL_W'(1);
            end
`ifdef ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
`endif
      end
   end

   decodificador #(.SEL_W(SEL_W)) u_dec (
      .sel_i (idx_q),
      .dec_o (dec)
   );

   assign gnt_valid = (state_q == S_GRANT);
   assign gnt_idx   = idx_q;
   assign gnt       = dec & {NREQ{gnt_valid}};
`ifdef ARB_TIMEOUT_EN
   assign timeout   = tmo_q;
`endif

endmodule

// File: tb/tb_arbitro_barramento.sv
// Bench for arbitro_barramento: directed scenarios plus random traffic, all
// checked against a transaction-level model (owner / round-robin start).
module tb_arbitro_barramento;
   logic       clock = 1'b0;
   logic       reset_n;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
   logic       timeout;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // model state
   int m_own;   // current owner, -1 when nobody holds the bus
   int m_rr;    // where the next round-robin scan starts
   int m_last;  // last owner index
   int m_hold;  // grant cycles already spent by owner, minus one
   bit m_to;    // forced release happened on last edge

   always #5 clock = ~clock;

   arbitro_barramento dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
     ,.timeout   (timeout)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_own = -1; m_rr = 0; m_last = 0; m_hold = 0; m_to = 0;
   endtask

   // One clock edge of arbiter behaviour, from the rules.
   task automatic m_step(input logic [7:0] r, input logic d);
      int pick;
      bit rel, frc;
      if (m_own < 0) begin
         m_to = 0;
         pick = -1;
         for (int k = 0; k < 8; k++)
            if (pick < 0 && r[(m_rr + k) % 8]) pick = (m_rr + k) % 8;
         if (pick >= 0) begin
            m_own = pick; m_last = pick; m_hold = 0;
         end
      end else begin
         rel = d || !r[m_own];
         frc = 0;
`ifdef ARB_TIMEOUT_EN
         frc = !rel && (m_hold == 15);
`endif
         if (rel || frc) begin
            m_rr  = (m_own + 1) % 8;
            m_own = -1;
            m_to  = frc;
         end else begin
            m_hold++;
            m_to = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] e;
      e = '0;
      if (m_own >= 0) e[m_own] = 1'b1;
      chk({tag, ".gnt"},   gnt,       e);
      chk({tag, ".valid"}, gnt_valid, (m_own >= 0));
      chk({tag, ".idx"},   gnt_idx,   m_last[2:0]);
      chk({tag, ".onehot"}, ($countones(gnt) <= 1), 1);
`ifdef ARB_TIMEOUT_EN
      chk({tag, ".tmo"},   timeout,   m_to);
`endif
   endtask

   // Apply inputs for one edge, step the model, check just after the edge.
   task automatic cyc(input string tag, input logic [7:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clock);
      m_step(r, d);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req = '0; done = 1'b0;
      m_reset();
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      req = '0; done = 1'b0;
      m_reset();
      #12;
      chk("rst.gnt", gnt, 8'h00);
      chk("rst.valid", gnt_valid, 0);
      chk("rst.idx", gnt_idx, 3'd0);
`ifdef ARB_TIMEOUT_EN
      chk("rst.tmo", timeout, 0);
`endif
      @(negedge clock);
      reset_n = 1'b1;

      // two requesters from idle, then hand-over with one dead cycle
      cyc("t2a", 8'h14, 0); chk("t2.first", gnt, 8'h04);
      cyc("t2b", 8'h14, 1); chk("t2.dead",  gnt, 8'h00);
      cyc("t2c", 8'h14, 0); chk("t2.next",  gnt, 8'h10);

      // wrap: owner 7 releases, next pick must be 0
      cyc("t3a", 8'h80, 1);
      cyc("t3b", 8'h80, 0); chk("t3.own7", gnt, 8'h80);
      cyc("t3c", 8'h81, 1);
      cyc("t3d", 8'h81, 0); chk("t3.wrap", gnt, 8'h01);

      // owner 3 drops its request while 6 raises
      cyc("t5a", 8'h08, 1);
      cyc("t5b", 8'h08, 0); chk("t5.own3", gnt, 8'h08);
      cyc("t5c", 8'h40, 0); chk("t5.dead", gnt, 8'h00);
      cyc("t5d", 8'h40, 0); chk("t5.own6", gnt, 8'h40);

      // all request, done once per grant: order 0..7,0
      do_reset();
      cyc("t4s", 8'hFF, 0); chk("t4.g0", gnt, 8'h01);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] e;
         e = '0; e[(i + 1) % 8] = 1'b1;
         cyc("t4r", 8'hFF, 1); chk("t4.gap", gnt, 8'h00);
         cyc("t4g", 8'hFF, 0); chk("t4.order", gnt, e);
      end

      // async reset in the middle of a grant to idx 5
      do_reset();
      cyc("t1a", 8'h20, 0); chk("t1.own5", gnt, 8'h20);
      #2 reset_n = 1'b0;
      #1;
      chk("t1.async.gnt", gnt, 8'h00);
      chk("t1.async.valid", gnt_valid, 0);
      m_reset();
      req = '0;
      @(negedge clock);
      reset_n = 1'b1;
      cyc("t1b", 8'h00, 0); chk("t1.quiet", gnt, 8'h00);
      cyc("t1c", 8'h00, 1); chk("t1.quiet2", gnt, 8'h00);

`ifdef ARB_TIMEOUT_EN
      // forced release after 16 grant cycles
      do_reset();
      begin
         int held, pulses;
         held = 0; pulses = 0;
         for (int i = 0; i < 18; i++) begin
            cyc("t6", 8'h03, 0);
            if (gnt == 8'h01) held++;
            if (timeout) pulses++;
         end
         chk("t6.held", held, 16);
         chk("t6.pulses", pulses, 1);
         chk("t6.next", gnt, 8'h02);
      end
`endif

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] r;
         logic       d;
         r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
         if ($urandom_range(0, 7) == 0) r = '0;
         d = ($urandom_range(0, 9) < 3);
         cyc("rnd", r, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
